mem_stage_lsu: RTL

//  Memory-stage load/store unit; sits directly upstream of the MEM/WB pipeline register and produces its ReadData input.

---
 rtl/mem_stage_lsu_if.sv | 24 ++
 rtl/mem_stage_lsu.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the memory-stage LSU (master) and data memory (slave).
// Word-addressed requests with byte enables; mem_ready both accepts and answers.
interface mem_stage_lsu_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     mem_req;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [3:0]               mem_be;
  logic                     mem_ready;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: aligns/extends loads, builds store byte enables, stalls while busy.
// Optional watchdog abort of a stuck transaction is enabled with the LSU_TIMEOUT_EN macro.
module mem_stage_lsu #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_MemReadM,
  input  logic                     i_MemWriteM,
  input  logic [2:0]               i_Funct3M,
  input  logic [ADDRESS_WIDTH-1:0] i_ALUResultM,
  input  logic [DATA_WIDTH-1:0]    i_WriteDataM,
  output logic [DATA_WIDTH-1:0]    o_ReadData,
  output logic                     o_StallM,
  output logic                     o_MisalignM,
  output logic                     o_BusErrM,
  mem_stage_lsu_if.master          io_mem
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t                   r_state;
  logic                     r_req;
  logic                     r_we;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [3:0]               r_be;
  logic [1:0]               r_offset;
  logic [2:0]               r_funct3;
  logic                     r_isLoad;
  logic [DATA_WIDTH-1:0]    r_readData;
  logic                     r_misalign;

  logic                     w_access;
  logic                     w_isLoad;
  logic [1:0]               w_offset;
  logic [2:0]               w_funct3;
  logic                     w_misalign;
  logic [3:0]               w_be;
  logic [DATA_WIDTH-1:0]    w_wdata;

  assign w_access = i_MemReadM | i_MemWriteM;
  assign w_isLoad = i_MemReadM;
  assign w_offset = i_ALUResultM[1:0];

  // Unknown size encodings behave as a full word.
  always_comb begin
    case (i_Funct3M)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_funct3 = i_Funct3M;
      default:                                w_funct3 = 3'b010;
    endcase
  end

  always_comb begin
    w_misalign = 1'b0;
    w_be       = 4'b1111;
    w_wdata    = i_WriteDataM;
    case (w_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_offset;
        w_wdata = {4{i_WriteDataM[7:0]}};
      end
      2'b01: begin
        w_misalign = w_offset[0];
        w_be       = w_offset[1] ? 4'b1100 : 4'b0011;
        w_wdata    = {2{i_WriteDataM[15:0]}};
      end
      default: w_misalign = |w_offset;
    endcase
    if (w_isLoad) w_be = 4'b1111;
  end

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off,
                                          input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b100:  extract = {24'b0, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b101:  extract = {16'b0, h};
      default: extract = word;
    endcase
  endfunction

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_count;
  logic          r_busErr;
  assign o_BusErrM = r_busErr;
`else
  logic w_unusedTimeout;
  assign w_unusedTimeout = (TIMEOUT_CYCLES != 0);
  assign o_BusErrM       = 1'b0;
`endif

  // DONE lasts one cycle so the M instruction can leave before a new access is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_offset   <= '0;
      r_funct3   <= '0;
      r_isLoad   <= 1'b0;
      r_readData <= '0;
      r_misalign <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      r_count    <= '0;
      r_busErr   <= 1'b0;
`endif
    end else begin
      r_misalign <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      r_busErr   <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            if (w_misalign) begin
              r_misalign <= 1'b1;
              r_readData <= '0;
            end else begin
              r_req    <= 1'b1;
              r_we     <= i_MemWriteM & ~i_MemReadM;
              r_addr   <= {i_ALUResultM[ADDRESS_WIDTH-1:2], 2'b00};
              r_be     <= w_be;
              r_wdata  <= w_wdata;
              r_offset <= w_offset;
              r_funct3 <= w_funct3;
              r_isLoad <= w_isLoad;
              r_state  <= ST_BUSY;
`ifdef LSU_TIMEOUT_EN
              r_count  <= '0;
`endif
            end
          end
        end
        ST_BUSY: begin
          if (io_mem.mem_ready) begin
            r_req <= 1'b0;
            if (r_isLoad) r_readData <= extract(io_mem.mem_rdata, r_offset, r_funct3);
            r_state <= ST_DONE;
          end
`ifdef LSU_TIMEOUT_EN
          else if (r_count == CW'(TIMEOUT_CYCLES - 1)) begin
            r_req      <= 1'b0;
            r_readData <= '0;
            r_busErr   <= 1'b1;
            r_state    <= ST_DONE;
          end else begin
            r_count <= r_count + 1'b1;
          end
`endif
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_StallM = ~rst & (((r_state == ST_IDLE) & w_access & ~w_misalign) |
                            (r_state == ST_BUSY));

  assign o_ReadData       = r_readData;
  assign o_MisalignM      = r_misalign;
  assign io_mem.mem_req   = r_req;
  assign io_mem.mem_we    = r_we;
  assign io_mem.mem_addr  = r_addr;
  assign io_mem.mem_wdata = r_wdata;
  assign io_mem.mem_be    = r_be;

endmodule
